// File: rtl/lsu_bus_master.sv
// Load/store bus master: one request at a time, byte-lane extract/extend on loads,
// read-modify-write for sub-doubleword stores onto a 64-bit-only bus.
module lsu_bus_master #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] direccion,
    output logic [63:0] dataWrite,
    output logic        memWr,
    input  logic [63:0] dataRead
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [2:0]  lane_q, lane_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] dir_q, dir_d;
    logic [63:0] dw_q, dw_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_wr_q, mem_wr_d;
    logic        resp_valid_q, resp_valid_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

    function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] s;
        s = raw >> {lane, 3'b000};
        case (size)
            2'd0:    return uns ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            2'd1:    return uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    return uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    // Replace only the addressed lanes; the rest keep what the bus returned.
    function automatic logic [63:0] merge(input logic [63:0] raw, input logic [63:0] wdata,
                                          input logic [2:0] lane, input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        m = m << {lane, 3'b000};
        return (raw & ~m) | ((wdata << {lane, 3'b000}) & m);
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        dir_d        = dir_q;
        dw_d         = dw_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        mem_wr_d     = 1'b0;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                size_d  = req_size;
                uns_d   = req_unsigned;
                lane_d  = req_addr[2:0];
                wdata_d = req_wdata;
                if (misaligned(req_size, req_addr[2:0])) begin
                    state_d      = RESP;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                    resp_valid_d = 1'b1;
                end else if (req_we && req_size == 2'd3) begin
                    state_d  = WR;
                    dir_d    = {req_addr[63:3], 3'b000};
                    dw_d     = req_wdata;
                    mem_wr_d = 1'b1;
                end else begin
                    state_d = RD;
                    dir_d   = {req_addr[63:3], 3'b000};
                    cnt_d   = '0;
                end
            end
            RD: if (cnt_q == LAT) begin
                if (we_q) begin
                    state_d  = WR;
                    dw_d     = merge(dataRead, wdata_q, lane_q, size_q);
                    mem_wr_d = 1'b1;
                end else begin
                    state_d      = RESP;
                    rdata_d      = load_ext(dataRead, lane_q, size_q, uns_q);
                    resp_valid_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            WR: begin
                state_d      = RESP;
                rdata_d      = '0;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            dir_q        <= '0;
            dw_q         <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            dir_q        <= dir_d;
            dw_q         <= dw_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_wr_q     <= mem_wr_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign direccion  = dir_q;
    assign dataWrite  = dw_q;
    assign memWr      = mem_wr_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: three instances (RD_LAT 0/1/3) share one bus model;
// expected responses are queued at request time and popped on resp_valid.
module tb_lsu_bus_master;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    typedef struct {
        int          resp_cyc;
        logic [63:0] rdata;
        logic        err;
        int          wr_cyc;
        logic [63:0] wdata;
        logic [63:0] dir;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       req_valid_v = '0;
    logic [2:0]       req_we_v = '0;
    logic [2:0]       req_unsigned_v = '0;
    logic [2:0][1:0]  req_size_v = '0;
    logic [2:0][63:0] req_addr_v = '0;
    logic [2:0][63:0] req_wdata_v = '0;
    wire  [2:0]       req_ready_v, resp_valid_v, resp_err_v, memWr_v;
    wire  [2:0][63:0] resp_rdata_v, direccion_v, dataWrite_v, dataRead_v;

    // Bus model: 32 doublewords of memory, switches/LEDs when address bit 12 is set.
    logic [63:0] mem [32];
    logic [63:0] switches = '0;
    logic [63:0] leds;
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = '0;
    logic [63:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        for (int i = 0; i < 3; i++) begin
            if (memWr_v[i]) begin
                if (direccion_v[i][12]) leds <= dataWrite_v[i];
                else                    mem[direccion_v[i][7:3]] <= dataWrite_v[i];
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign dataRead_v[g] = direccion_v[g][12] ? switches : mem[direccion_v[g][7:3]];
        lsu_bus_master #(.RD_LAT(lat_of(g))) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid_v[g]),
            .req_ready    (req_ready_v[g]),
            .req_we       (req_we_v[g]),
            .req_size     (req_size_v[g]),
            .req_unsigned (req_unsigned_v[g]),
            .req_addr     (req_addr_v[g]),
            .req_wdata    (req_wdata_v[g]),
            .resp_valid   (resp_valid_v[g]),
            .resp_rdata   (resp_rdata_v[g]),
            .resp_err     (resp_err_v[g]),
            .direccion    (direccion_v[g]),
            .dataWrite    (dataWrite_v[g]),
            .memWr        (memWr_v[g]),
            .dataRead     (dataRead_v[g])
        );
    end

    task automatic bd_write(input int idx, input logic [63:0] data);
        bd_we   = 1'b1;
        bd_idx  = 5'(idx);
        bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issue one request on instance g and track it cycle by cycle (k = cycles after accept).
    task automatic do_req(input int g, input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err, input int exp_resp,
                          input int exp_wr, input logic [63:0] exp_wdata, input bit poke);
        exp_t e;
        exp_t r;
        int   k;
        bit   done;
        e.resp_cyc = exp_resp;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        e.wr_cyc   = exp_wr;
        e.wdata    = exp_wdata;
        e.dir      = exp_err ? direccion_v[g] : {addr[63:3], 3'b000};
        sb_q.push_back(e);
        req_valid_v[g]    = 1'b1;
        req_we_v[g]       = we;
        req_size_v[g]     = size;
        req_unsigned_v[g] = uns;
        req_addr_v[g]     = addr;
        req_wdata_v[g]    = wdata;
        @(posedge clk); #1;
        req_valid_v[g] = 1'b0;
        k    = 1;
        done = 0;
        while (!done && k <= 12) begin
            if (poke && k == 1) begin
                req_valid_v[g] = 1'b1;
                req_we_v[g]    = 1'b1;
                req_size_v[g]  = 2'd3;
                req_addr_v[g]  = 64'h30;
            end else if (poke && k == 2) begin
                req_valid_v[g] = 1'b0;
            end
            n_asserts++;
            if (req_ready_v[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_busy g%0d k%0d: got %b want 0", g, k, req_ready_v[g]);
            end
            n_asserts++;
            if (memWr_v[g] !== (k == e.wr_cyc)) begin
                n_fail++;
                $display("FAIL memwr_timing g%0d k%0d: got %b want %b", g, k, memWr_v[g], k == e.wr_cyc);
            end
            if (k == e.wr_cyc) begin
                n_asserts++;
                if (dataWrite_v[g] !== e.wdata || direccion_v[g] !== e.dir) begin
                    n_fail++;
                    $display("FAIL wr_data g%0d: got %h @%h want %h @%h", g, dataWrite_v[g],
                             direccion_v[g], e.wdata, e.dir);
                end
            end
            if (k == 1) begin
                n_asserts++;
                if (direccion_v[g] !== e.dir) begin
                    n_fail++;
                    $display("FAIL direccion g%0d: got %h want %h", g, direccion_v[g], e.dir);
                end
            end
            if (resp_valid_v[g]) begin
                n_asserts++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp g%0d k%0d: got resp want none", g, k);
                end else begin
                    r = sb_q.pop_front();
                    if (k !== r.resp_cyc || resp_rdata_v[g] !== r.rdata || resp_err_v[g] !== r.err) begin
                        n_fail++;
                        $display("FAIL resp g%0d: got k%0d data %h err %b want k%0d data %h err %b",
                                 g, k, resp_rdata_v[g], resp_err_v[g], r.resp_cyc, r.rdata, r.err);
                    end
                end
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!done) begin
            n_asserts++;
            n_fail++;
            $display("FAIL resp_timeout g%0d: got no resp want k%0d", g, exp_resp);
            sb_q.delete();
        end
        @(posedge clk); #1;
        n_asserts++;
        if (req_ready_v[g] !== 1'b1 || memWr_v[g] !== 1'b0 || resp_valid_v[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after g%0d: got rdy %b wr %b rv %b want 1 0 0", g,
                     req_ready_v[g], memWr_v[g], resp_valid_v[g]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            n_asserts++;
            if (req_ready_v[g] !== 1'b1 || resp_valid_v[g] !== 1'b0 || resp_err_v[g] !== 1'b0 ||
                memWr_v[g] !== 1'b0 || resp_rdata_v[g] !== 64'h0 || direccion_v[g] !== 64'h0 ||
                dataWrite_v[g] !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_state g%0d: got rdy %b rv %b err %b wr %b rd %h dir %h dw %h want 1 0 0 0 0 0 0",
                         g, req_ready_v[g], resp_valid_v[g], resp_err_v[g], memWr_v[g],
                         resp_rdata_v[g], direccion_v[g], dataWrite_v[g]);
            end
        end
    endtask

    task automatic test_load();
        bd_write(2, 64'h8877665544332211);
        do_req(1, 0, 2'd3, 0, 64'h10, 0, 64'h8877665544332211, 0, 3, 0, 0, 0);
        do_req(1, 0, 2'd0, 0, 64'h17, 0, 64'hFFFFFFFFFFFFFF88, 0, 3, 0, 0, 0);
        do_req(1, 0, 2'd0, 1, 64'h17, 0, 64'h0000000000000088, 0, 3, 0, 0, 1);
        do_req(1, 0, 2'd1, 0, 64'h12, 0, 64'h0000000000004433, 0, 3, 0, 0, 0);
        do_req(1, 0, 2'd2, 0, 64'h14, 0, 64'hFFFFFFFF88776655, 0, 3, 0, 0, 0);
    endtask

    task automatic test_rmw_store();
        bd_write(2, 64'h1111111111111111);
        do_req(1, 1, 2'd0, 0, 64'h13, 64'hFFFFFFFFFFFFFFAB, 0, 0, 4, 3, 64'h11111111AB111111, 0);
        do_req(1, 1, 2'd1, 0, 64'h16, 64'h000000000000BEEF, 0, 0, 4, 3, 64'hBEEF1111AB111111, 0);
        do_req(1, 0, 2'd3, 0, 64'h10, 0, 64'hBEEF1111AB111111, 0, 3, 0, 0, 0);
    endtask

    task automatic test_sd_misaligned();
        do_req(1, 1, 2'd3, 0, 64'h20, 64'hDEADBEEFCAFEF00D, 0, 0, 2, 1, 64'hDEADBEEFCAFEF00D, 0);
        do_req(1, 0, 2'd2, 0, 64'h22, 0, 0, 1, 1, 0, 0, 0);
        do_req(1, 1, 2'd1, 0, 64'h21, 64'h1234, 0, 1, 1, 0, 0, 0);
        do_req(1, 0, 2'd3, 0, 64'h20, 0, 64'hDEADBEEFCAFEF00D, 0, 3, 0, 0, 0);
    endtask

    task automatic test_io();
        switches = 64'h0F;
        do_req(1, 1, 2'd0, 0, 64'h1000, 64'h5A, 0, 0, 4, 3, 64'h000000000000005A, 0);
        n_asserts++;
        if (leds !== 64'h5A) begin
            n_fail++;
            $display("FAIL leds: got %h want %h", leds, 64'h5A);
        end
        do_req(1, 0, 2'd0, 0, 64'h1000, 0, 64'h000000000000000F, 0, 3, 0, 0, 0);
    endtask

    task automatic test_reset_midflight(input int g);
        int          lat;
        logic [63:0] v;
        bit          quiet;
        lat = lat_of(g);
        req_valid_v[g] = 1'b1;
        req_we_v[g]    = 1'b1;
        req_size_v[g]  = 2'd0;
        req_addr_v[g]  = 64'h08;
        req_wdata_v[g] = 64'h77;
        @(posedge clk); #1;
        req_valid_v[g] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_asserts++;
        if (req_ready_v[g] !== 1'b1 || memWr_v[g] !== 1'b0 || resp_valid_v[g] !== 1'b0 ||
            direccion_v[g] !== 64'h0) begin
            n_fail++;
            $display("FAIL midflight_reset g%0d: got rdy %b wr %b rv %b dir %h want 1 0 0 0", g,
                     req_ready_v[g], memWr_v[g], resp_valid_v[g], direccion_v[g]);
        end
        quiet = 1;
        repeat (6) begin
            @(posedge clk); #1;
            if (memWr_v[g] !== 1'b0 || resp_valid_v[g] !== 1'b0) quiet = 0;
        end
        n_asserts++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL dropped_req g%0d: got bus/resp activity want none", g);
        end
        do_req(g, 0, 2'd3, 0, 64'h08, 0, 64'h0101010101010101, 0, 2 + lat, 0, 0, 0);
        v = 64'(10 + g) * 64'h0101010101010101;
        do_req(g, 1, 2'd0, 0, 64'h51 + 64'(8 * g), 64'hCC, 0, 0, 3 + lat, 2 + lat,
               (v & ~64'hFF00) | 64'hCC00, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bd_write(i, 64'(i) * 64'h0101010101010101);
        test_reset();
        test_load();
        test_rmw_store();
        test_sd_misaligned();
        test_io();
        for (int g = 0; g < 3; g++) test_reset_midflight(g);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Processor-side initiator for the data-memory/IO bus: load/store unit master.
- Accepts one load/store request at a time from the execute stage, drives `direccion`, `dataWrite` and `memWr` on the bus, and captures `dataRead`.
- Performs byte-lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-doubleword stores; the bus only writes full 64-bit doublewords.
- Sits between the pipeline and the DM/IO decoder. Bus address bit 12 selects IO: switches on read, LEDs on write.

Parameters:
- RD_LAT, 1, bus read latency in cycles from address drive to valid `dataRead` (legal 0..3).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned access, valid with resp_valid
- direccion  out  64  bus address, always doubleword aligned ([2:0] = 0)
- dataWrite  out  64  bus write data
- memWr  out  1  bus write strobe, registered
- dataRead  in  64  bus read data

Behaviour:
- Reset (synchronous, sampled on a clk edge):
  - State returns to IDLE.
  - `req_ready` = 1.
  - `resp_valid`, `resp_err`, `memWr` = 0.
  - `resp_rdata`, `direccion`, `dataWrite` = 0.
  - An in-flight request is dropped with no response.
  - A `memWr` that is high in the cycle reset is sampled still completes at that edge; no further write is issued.
- States:
  - IDLE: `req_ready` = 1.
  - RD: address driven, `memWr` = 0, RD_LAT wait counter running.
  - WR: `memWr` = 1 for exactly one cycle.
  - RESP: `resp_valid` = 1 for one cycle, then IDLE.
- Accept: request captured on edge T when req_valid && req_ready. `req_ready` is 0 from T+1 until the cycle after the RESP cycle.
- Alignment check: the access is misaligned when `req_addr` is not a multiple of 2^req_size. A misaligned request makes no bus access: RESP at T+1 with `resp_err` = 1 and `resp_rdata` = 0.
- Lane = addr[2:0], little-endian. Byte k occupies bits [8k+7:8k].
- Load:
  - `direccion` = {addr[63:3], 3'b000} from T+1.
  - `dataRead` sampled in cycle T+1+RD_LAT (with RD_LAT = 0, sampled in T+1).
  - The selected lanes are shifted to bit 0 and extended per `req_unsigned`. A doubleword load ignores `req_unsigned`.
  - RESP at T+2+RD_LAT.
- Store, size 3: WR at T+1 with `dataWrite` = `req_wdata`. RESP at T+2.
- Store, size 0..2 (read-modify-write):
  - RD as for a load.
  - Merge into the sampled doubleword: replace the addressed lanes with the low bytes of `req_wdata`; all other lanes keep their read value.
  - WR at T+2+RD_LAT, same `direccion`.
  - RESP at T+3+RD_LAT.
- IO region: addresses with bit 12 set receive identical treatment. A byte store to 0x1000 reads the switches, merges lane 0, and writes; the LEDs receive `req_wdata[7:0]`.
- Store responses: `resp_rdata` = 0, `resp_err` = 0.
- `req_valid` during a busy cycle is ignored; the request is not queued.
- No response backpressure: `resp_valid` is a pulse.
- `direccion` and `dataWrite` hold their last values in IDLE.
- `memWr` is never high outside WR.

Test Plan:
- LD 0x10, RD_LAT = 1, bus returns 0x8877665544332211 → resp_valid at T+3, resp_rdata = 0x8877665544332211, `memWr` never high.
- LB 0x17 signed, same data → direccion = 0x10, resp_rdata = 0xFFFFFFFFFFFFFF88. LBU 0x17 → 0x0000000000000088. LH 0x12 → 0x0000000000004433.
- SB 0x13, wdata 0xAB, memory holds 0x1111111111111111 → single WR cycle at T+3 with dataWrite = 0x11111111AB111111, resp_valid at T+4.
- SD 0x20, wdata 0xDEADBEEFCAFEF00D → `memWr` high only at T+1 with that data, resp at T+2. LW 0x22 → resp_err = 1 at T+1, no bus activity.
- SB 0x1000, wdata 0x5A, switches = 0x0F → dataWrite = 0x000000000000005A with `memWr` = 1. LB 0x1000 → resp_rdata = 0x000000000000000F.
- Reset asserted the cycle after accepting SB 0x08 (during RD) → no `memWr`, no resp_valid, req_ready = 1 next cycle, a new LD 0x08 completes normally. Repeat with RD_LAT = 0 and RD_LAT = 3, checking the latency shifts.
